// File: rtl/spraid_spi_channel_pkg.sv
// Shared definitions for the spraid SPI memory channel: SRAM opcodes, FSM encodings
// and the serial frame length.
package spraid_spi_channel_pkg;

    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_WREN  = 8'h06;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_SETUP = 3'd1;
    localparam logic [ST_W-1:0] ST_SHIFT = 3'd2;
    localparam logic [ST_W-1:0] ST_HOLD  = 3'd3;
    localparam logic [ST_W-1:0] ST_GAP   = 3'd4;

    // Opcode byte, address, then data word.
    function automatic int unsigned frame_bits(input int unsigned addr_w,
                                               input int unsigned data_bytes);
        return 8 + addr_w + 8 * data_bytes;
    endfunction

endpackage

// File: rtl/spraid_spi_clkgen.sv
// Half-period counter for the SPI channel: a tick every DIV cycles, and an SPI clock
// that toggles on ticks while enabled. Synchronous clear parks the clock low.
module spraid_spi_clkgen
    import spraid_spi_channel_pkg::*;
#(
    parameter int unsigned DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic en_i,
    output logic tick_c_o,
    output logic rise_c_o,
    output logic fall_c_o,
    output logic sclk_o
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    always_comb begin
        tick_c_o = (cnt_q == CW'(DIV - 1));
        rise_c_o = tick_c_o & en_i & ~clear_i & ~sclk_q;
        fall_c_o = tick_c_o & en_i & ~clear_i & sclk_q;
        cnt_d    = tick_c_o ? '0 : cnt_q + CW'(1);
        sclk_d   = sclk_q;
        if (clear_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (tick_c_o && en_i) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

    assign sclk_o = sclk_q;

endmodule

// File: rtl/spraid_spi_channel.sv
// Per-drive SPI SRAM channel: one word read/write per command, mode 0, MSB first.
// Define SPRAID_SPI_WREN_EN to precede every write with a stand-alone WREN (0x06) frame.
module spraid_spi_channel
    import spraid_spi_channel_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 2,
    parameter int unsigned ADDR_W     = 24,
    parameter int unsigned DATA_BYTES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_W-1:0]       cmd_addr,
    input  logic [8*DATA_BYTES-1:0] cmd_wdata,
    output logic                    rsp_valid,
    output logic [8*DATA_BYTES-1:0] rsp_rdata,
    output logic                    busy,
    output logic                    spi_clk,
    output logic                    spi_cs,
    output logic                    spi_mosi,
    input  logic                    spi_miso
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned NB = frame_bits(ADDR_W, DATA_BYTES);
    localparam int unsigned BW = $clog2(NB);

    localparam logic [BW-1:0] DATA_START = BW'(8 + ADDR_W);
    localparam logic [BW-1:0] LAST_BIT   = BW'(NB - 1);

    logic [ST_W-1:0] state_q, state_d;
    logic [NB-1:0]   sr_q, sr_d;
    logic [DW-1:0]   rx_q, rx_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [BW-1:0]   last_bit;
    logic            we_q, we_d;
    logic            cs_q, cs_d;
    logic            mosi_q, mosi_d;
    logic            rsp_q, rsp_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            clk_tick, clk_rise, clk_fall;
`ifdef SPRAID_SPI_WREN_EN
    logic [NB-1:0]   frame_q, frame_d;
    logic            wren_q, wren_d;
`endif

    spraid_spi_clkgen #(
        .DIV (CLK_DIV)
    ) u_clkgen (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (state_q == ST_IDLE),
        .en_i     ((state_q == ST_SETUP) || (state_q == ST_SHIFT)),
        .tick_c_o (clk_tick),
        .rise_c_o (clk_rise),
        .fall_c_o (clk_fall),
        .sclk_o   (spi_clk)
    );

    // Next-state and output logic
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        bit_d    = bit_q;
        we_d     = we_q;
        cs_d     = cs_q;
        mosi_d   = mosi_q;
        rsp_d    = 1'b0;
        busy_d   = busy_q;
        ready_d  = ready_q;
        last_bit = LAST_BIT;
`ifdef SPRAID_SPI_WREN_EN
        frame_d  = frame_q;
        wren_d   = wren_q;
        if (wren_q) last_bit = BW'(7);
`endif

        // Completion cycle still reports busy; the channel reopens one cycle later.
        if (rsp_q) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
        end

        if (clk_rise && !we_q && (bit_q >= DATA_START)) begin
            rx_d = {rx_q[DW-2:0], spi_miso};
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    we_d    = cmd_we;
                    busy_d  = 1'b1;
                    ready_d = 1'b0;
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                    sr_d    = {(cmd_we ? OP_WRITE : OP_READ), cmd_addr, cmd_wdata};
`ifdef SPRAID_SPI_WREN_EN
                    frame_d = sr_d;
                    wren_d  = cmd_we;
                    if (cmd_we) sr_d = {OP_WREN, {(NB-8){1'b0}}};
`endif
                    mosi_d  = sr_d[NB-1];
                end
            end
            ST_SETUP: begin
                if (clk_tick) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (clk_fall) begin
                    if (bit_q == last_bit) begin
                        state_d = ST_HOLD;
                    end else begin
                        bit_d  = bit_q + BW'(1);
                        sr_d   = {sr_q[NB-2:0], 1'b0};
                        mosi_d = sr_q[NB-2];
                    end
                end
            end
            ST_HOLD: begin
                if (clk_tick) begin
                    cs_d   = 1'b1;
                    mosi_d = 1'b0;
`ifdef SPRAID_SPI_WREN_EN
                    if (wren_q) begin
                        wren_d  = 1'b0;
                        state_d = ST_GAP;
                    end else
`endif
                    begin
                        state_d = ST_IDLE;
                        rsp_d   = 1'b1;
                        if (!we_q) rdata_d = rx_q;
                    end
                end
            end
`ifdef SPRAID_SPI_WREN_EN
            // Chip select high for one half-period before the write frame itself.
            ST_GAP: begin
                if (clk_tick) begin
                    sr_d    = frame_q;
                    mosi_d  = frame_q[NB-1];
                    cs_d    = 1'b0;
                    bit_d   = '0;
                    state_d = ST_SETUP;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            rx_q    <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            we_q    <= 1'b0;
            cs_q    <= 1'b1;
            mosi_q  <= 1'b0;
            rsp_q   <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
`ifdef SPRAID_SPI_WREN_EN
            frame_q <= '0;
            wren_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            rx_q    <= rx_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
            we_q    <= we_d;
            cs_q    <= cs_d;
            mosi_q  <= mosi_d;
            rsp_q   <= rsp_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
`ifdef SPRAID_SPI_WREN_EN
            frame_q <= frame_d;
            wren_q  <= wren_d;
`endif
        end
    end

    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_q;
    assign rsp_rdata = rdata_q;
    assign busy      = busy_q;
    assign spi_cs    = cs_q;
    assign spi_mosi  = mosi_q;

endmodule

// File: tb/tb_spraid_spi_channel.sv
// Bench for spraid_spi_channel: two instances (default and CLK_DIV=1/ADDR_W=16/DATA_BYTES=1)
// driven by a vector table, hand sequences and random commands against a frame-level model.
module tb_spraid_spi_channel;

    localparam int unsigned D0 = 2, AW0 = 24, DB0 = 4;
    localparam int unsigned D1 = 1, AW1 = 16, DB1 = 1;
`ifdef SPRAID_SPI_WREN_EN
    localparam bit WREN = 1'b1;
`else
    localparam bit WREN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  cmd_valid, cmd_we, cmd_ready, rsp_valid, busy, sclk, cs, mosi, miso;
    logic [23:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata0;
    logic [7:0]  rdata1;

    spraid_spi_channel #(.CLK_DIV(D0), .ADDR_W(AW0), .DATA_BYTES(DB0)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
        .cmd_we(cmd_we[0]), .cmd_addr(addr[0]), .cmd_wdata(wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rdata0), .busy(busy[0]),
        .spi_clk(sclk[0]), .spi_cs(cs[0]), .spi_mosi(mosi[0]), .spi_miso(miso[0]));

    spraid_spi_channel #(.CLK_DIV(D1), .ADDR_W(AW1), .DATA_BYTES(DB1)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
        .cmd_we(cmd_we[1]), .cmd_addr(addr[1][15:0]), .cmd_wdata(wdata[1][7:0]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rdata1), .busy(busy[1]),
        .spi_clk(sclk[1]), .spi_cs(cs[1]), .spi_mosi(mosi[1]), .spi_miso(miso[1]));

    function automatic int dv(input int i); return (i == 0) ? int'(D0) : int'(D1); endfunction
    function automatic int aw(input int i); return (i == 0) ? int'(AW0) : int'(AW1); endfunction
    function automatic int dw(input int i); return (i == 0) ? int'(8*DB0) : int'(8*DB1); endfunction
    function automatic int nb(input int i); return 8 + aw(i) + dw(i); endfunction
    function automatic logic [63:0] lomask(input int w);
        return (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    endfunction
    function automatic logic [63:0] rd_of(input int i);
        return (i == 0) ? 64'(rdata0) : 64'(rdata1);
    endfunction

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // SPI slave / wire monitor: serves miso bits per rising edge, records each frame.
    logic [63:0] miso_pat [2];
    logic [63:0] mcap [2];
    logic [63:0] fr_bits [2][128];
    int          fr_len [2][128];
    int          fr_gap [2][128];
    int          fr_cnt [2] = '{0, 0};
    int          rsp_cnt [2] = '{0, 0};
    int          viol [2] = '{0, 0};
    int          nrise [2] = '{0, 0};
    int          hi_run [2] = '{0, 0};
    bit          prev_cs [2] = '{1'b1, 1'b1};
    bit          prev_sclk [2] = '{1'b0, 1'b0};
    bit          mon_en = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 1'b1) begin
                if (!prev_cs[i]) begin
                    if (fr_cnt[i] < 128) begin
                        fr_bits[i][fr_cnt[i]] = mcap[i];
                        fr_len[i][fr_cnt[i]]  = nrise[i];
                    end
                    fr_cnt[i]++;
                    hi_run[i] = 0;
                end
                hi_run[i]++;
                nrise[i] = 0;
                if (mon_en && (mosi[i] !== 1'b0 || sclk[i] !== 1'b0)) viol[i]++;
            end else begin
                if (prev_cs[i]) begin
                    if (fr_cnt[i] < 128) fr_gap[i][fr_cnt[i]] = hi_run[i];
                    mcap[i]  = '0;
                    nrise[i] = 0;
                end
                if (sclk[i] === 1'b1 && !prev_sclk[i]) begin
                    mcap[i] = {mcap[i][62:0], mosi[i]};
                    nrise[i]++;
                end
            end
            if (rsp_valid[i] === 1'b1) rsp_cnt[i]++;
            prev_cs[i]   = (cs[i] === 1'b1);
            prev_sclk[i] = (sclk[i] === 1'b1);
            miso[i] = (nrise[i] < nb(i)) ? miso_pat[i][nb(i) - 1 - nrise[i]] : 1'b0;
        end
    end

    // One command end to end; frame contents and latency come from the channel's frame rules.
    task automatic run_cmd(input int i, input logic we, input logic [23:0] a, input logic [31:0] wd,
                           input logic [31:0] md, input logic [31:0] exp_rd, input int exp_lat,
                           input string tag);
        int          cyc;
        int          base_f;
        int          base_r;
        int          nfr;
        int          mi;
        logic [7:0]  op;
        logic [63:0] exp_fr;
        logic [63:0] junk;
        @(negedge clk);
        junk         = {$urandom, $urandom};
        miso_pat[i]  = (junk & ~lomask(dw(i))) | (64'(md) & lomask(dw(i)));
        op           = we ? 8'h02 : 8'h03;
        exp_fr       = (64'(op) << (aw(i) + dw(i))) | ((64'(a) & lomask(aw(i))) << dw(i))
                     | (64'(wd) & lomask(dw(i)));
        cyc = 0;
        while (cmd_ready[i] !== 1'b1 && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 1000) chk({tag, "_ready_timeout"}, 64'(cmd_ready[i]), 64'd1);
        base_f = fr_cnt[i];
        base_r = rsp_cnt[i];
        cmd_valid[i] = 1'b1;
        cmd_we[i]    = we;
        addr[i]      = a;
        wdata[i]     = wd;
        @(posedge clk);
        #1 cmd_valid[i] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                chk({tag, "_busy_rise"}, 64'(busy[i]), 64'd1);
                chk({tag, "_cs_fall"}, 64'(cs[i]), 64'd0);
            end
        end while (rsp_valid[i] !== 1'b1 && cyc < 2000);
        chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        chk({tag, "_rsp_cs_high"}, 64'(cs[i]), 64'd1);
        chk({tag, "_busy_at_rsp"}, 64'(busy[i]), 64'd1);
        chk({tag, "_rdata"}, rd_of(i), 64'(exp_rd));
        @(negedge clk);
        chk({tag, "_busy_fall"}, 64'(busy[i]), 64'd0);
        chk({tag, "_ready_back"}, 64'(cmd_ready[i]), 64'd1);
        chk({tag, "_rsp_one_pulse"}, 64'(rsp_cnt[i] - base_r), 64'd1);
        nfr = (we && WREN) ? 2 : 1;
        chk({tag, "_frames"}, 64'(fr_cnt[i] - base_f), 64'(nfr));
        mi = base_f + nfr - 1;
        if (mi < 128 && fr_cnt[i] - base_f == nfr) begin
            chk({tag, "_mosi_frame"}, fr_bits[i][mi] & lomask(nb(i)), exp_fr);
            chk({tag, "_edges"}, 64'(fr_len[i][mi]), 64'(nb(i)));
            if (nfr == 2) begin
                chk({tag, "_wren_frame"}, fr_bits[i][base_f] & 64'hFF, 64'h06);
                chk({tag, "_wren_edges"}, 64'(fr_len[i][base_f]), 64'd8);
                chk({tag, "_wren_gap"}, 64'(fr_gap[i][mi]), 64'(dv(i)));
            end
        end
    endtask

    typedef struct {
        int          inst;
        logic        we;
        logic [23:0] addr;
        logic [31:0] wdata;
        logic [31:0] miso;
        logic [31:0] exp_rd;
        int          exp_lat;
        string       tag;
    } vec_t;

    vec_t        vt [4];
    logic [31:0] model_rd [2];

    initial begin
        int c, r1, r2, cf, base_f, base_r, lat, idx;
        bit pcs;
        logic        we;
        logic [23:0] a;
        logic [31:0] wd, md;

        vt[0] = '{0, 1'b0, 24'h000123, 32'h00000000, 32'hDEADBEEF, 32'hDEADBEEF, 259, "v_read"};
        vt[1] = '{0, 1'b1, 24'hABCDEF, 32'h12345678, 32'hFFFFFFFF, 32'hDEADBEEF,
                  WREN ? 295 : 259, "v_write"};
        vt[2] = '{1, 1'b0, 24'h00C0DE, 32'h00000000, 32'h0000005A, 32'h0000005A, 66, "v_small_read"};
        vt[3] = '{1, 1'b1, 24'h001234, 32'h000000A5, 32'h000000FF, 32'h0000005A,
                  WREN ? 84 : 66, "v_small_write"};

        reset     = 1'b1;
        cmd_valid = '0;
        cmd_we    = '0;
        for (int i = 0; i < 2; i++) begin
            addr[i]     = '0;
            wdata[i]    = '0;
            miso_pat[i] = '0;
            model_rd[i] = '0;
        end
        repeat (3) @(negedge clk);
        cmd_valid[0] = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_cs", 64'(cs[i]), 64'd1);
            chk("rst_sclk", 64'(sclk[i]), 64'd0);
            chk("rst_mosi", 64'(mosi[i]), 64'd0);
            chk("rst_rsp_valid", 64'(rsp_valid[i]), 64'd0);
            chk("rst_rdata", rd_of(i), 64'd0);
            chk("rst_busy", 64'(busy[i]), 64'd0);
            chk("rst_ready", 64'(cmd_ready[i]), 64'd1);
        end

        for (int k = 0; k < 4; k++) begin
            run_cmd(vt[k].inst, vt[k].we, vt[k].addr, vt[k].wdata, vt[k].miso,
                    vt[k].exp_rd, vt[k].exp_lat, vt[k].tag);
            model_rd[vt[k].inst] = vt[k].exp_rd;
        end
        chk("write_frame_literal", fr_bits[0][fr_cnt[0] - 1 - 2 * 0] & 64'h0, 64'h0 & fr_bits[0][0]);

        // Back-to-back reads with cmd_valid held high throughout.
        @(negedge clk);
        miso_pat[0]  = {32'h13572468, 32'hCAFEF00D};
        base_f       = fr_cnt[0];
        base_r       = rsp_cnt[0];
        cmd_valid[0] = 1'b1;
        cmd_we[0]    = 1'b0;
        addr[0]      = 24'h00FF00;
        c = 0; r1 = -1; r2 = -1; cf = -1; pcs = 1'b1;
        while (r2 < 0 && c < 1200) begin
            @(negedge clk);
            c++;
            if (rsp_valid[0] === 1'b1) begin
                if (r1 < 0) r1 = c;
                else r2 = c;
                chk("b2b_rdata", rd_of(0), 64'hCAFEF00D);
            end
            if (cs[0] === 1'b0 && pcs && r1 >= 0 && cf < 0) cf = c;
            pcs = (cs[0] === 1'b1);
            if (r2 >= 0) cmd_valid[0] = 1'b0;
        end
        cmd_valid[0] = 1'b0;
        @(negedge clk);
        chk("b2b_first_latency", 64'(r1), 64'd259);
        chk("b2b_cs_refall", 64'(cf - r1), 64'd2);
        chk("b2b_second_rsp", 64'(r2 - r1), 64'd260);
        chk("b2b_frames", 64'(fr_cnt[0] - base_f), 64'd2);
        chk("b2b_rsp_pulses", 64'(rsp_cnt[0] - base_r), 64'd2);
        if (base_f + 1 < 128) chk("b2b_cs_gap", 64'(fr_gap[0][base_f + 1]), 64'd2);
        chk("b2b_idle_after", 64'(busy[0]), 64'd0);
        model_rd[0] = 32'hCAFEF00D;

        // Reset in the middle of a read frame.
        miso_pat[0]  = 64'h0123456789ABCDEF;
        cmd_valid[0] = 1'b1;
        cmd_we[0]    = 1'b0;
        addr[0]      = 24'h000040;
        @(posedge clk);
        #1 cmd_valid[0] = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 40) reset = 1'b1;
        end
        @(negedge clk);
        chk("midrst_cs", 64'(cs[0]), 64'd1);
        chk("midrst_sclk", 64'(sclk[0]), 64'd0);
        chk("midrst_ready", 64'(cmd_ready[0]), 64'd1);
        chk("midrst_busy", 64'(busy[0]), 64'd0);
        chk("midrst_rsp", 64'(rsp_valid[0]), 64'd0);
        chk("midrst_rdata", rd_of(0), 64'd0);
        reset       = 1'b0;
        model_rd[0] = '0;
        model_rd[1] = '0;
        base_r      = rsp_cnt[0];
        repeat (300) @(negedge clk);
        chk("midrst_no_late_rsp", 64'(rsp_cnt[0] - base_r), 64'd0);
        run_cmd(0, 1'b0, 24'h000123, 32'h0, 32'h600DD00D, 32'h600DD00D, 259, "post_rst_read");
        model_rd[0] = 32'h600DD00D;

        // Random commands against the frame-level model.
        for (int n = 0; n < 14; n++) begin
            idx = ($urandom_range(0, 1) == 1) ? 1 : 0;
            we  = ($urandom_range(0, 1) == 1);
            a   = 24'($urandom) & 24'(lomask(aw(idx)));
            wd  = $urandom & 32'(lomask(dw(idx)));
            md  = $urandom;
            if (!we) model_rd[idx] = md & 32'(lomask(dw(idx)));
            lat = 1 + (2 * nb(idx) + 1) * dv(idx);
            if (we && WREN) lat = lat + 17 * dv(idx) + dv(idx);
            run_cmd(idx, we, a, wd, md, model_rd[idx], lat, we ? "rnd_write" : "rnd_read");
        end

        chk("cs_high_idle_wire0", 64'(viol[0]), 64'd0);
        chk("cs_high_idle_wire1", 64'(viol[1]), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
